// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding and
// default prescaler divisors.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAST = 2'd2
    } pc_state_e;

    localparam int DEF_SLOW_DIV = 25_000_000;
    localparam int DEF_FAST_DIV = 250_000;

endpackage

// File: rtl/pc_sequencer_edge_sync.sv
// Two-flop synchronizer plus history flop producing a one-cycle pulse on each
// rising transition of an asynchronous button level.
module edge_sync
    import pc_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic       sync1_q, sync2_q, hist_q;
    logic       sync1_d, sync2_d, hist_d;
    logic [2:0] fill_q, fill_d;

    // fill_q marks when the history flop holds a real sample rather than its
    // reset value, so a button held through reset never looks like a new edge.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        fill_d  = {fill_q[1:0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            fill_q  <= 3'b000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    assign rise = sync2_q & ~hist_q & fill_q[2];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: single-step, slow run and fast run modes with a
// shared prescaler, synchronous jump and halt, and carry-out pulse.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SLOW_DIV = DEF_SLOW_DIV,
    parameter int FAST_DIV = DEF_FAST_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next_btn,
    input  logic             run_btn,
    input  logic             fast_btn,
    input  logic             halt,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] pc,
    output logic [1:0]       state,
    output logic             adv,
    output logic             wrap
);

    localparam int              PW       = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [PW-1:0]   SLOW_MAX = PW'(SLOW_DIV - 1);
    localparam logic [PW-1:0]   FAST_MAX = PW'(FAST_DIV - 1);

    logic [1:0] rst_sync_q;
    logic       rst_int;

    // Reset asserts immediately but releases two clock edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    logic next_ev, run_ev, fast_ev;

    edge_sync u_next (.clk(clk), .rst(rst_int), .btn(next_btn), .rise(next_ev));
    edge_sync u_run  (.clk(clk), .rst(rst_int), .btn(run_btn),  .rise(run_ev));
    edge_sync u_fast (.clk(clk), .rst(rst_int), .btn(fast_btn), .rise(fast_ev));

    pc_state_e        state_q, state_d, cur_state;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    presc_q, presc_d, div_max;
    logic             adv_q, adv_d, wrap_q, wrap_d;
    logic             tick, adv_now;
    logic [WIDTH:0]   sum;

    always_comb begin
        case (state_q)
            ST_RUN:  cur_state = ST_RUN;
            ST_FAST: cur_state = ST_FAST;
            default: cur_state = ST_IDLE;
        endcase

        state_d = cur_state;
        if (halt)         state_d = ST_IDLE;
        else if (fast_ev) state_d = ST_FAST;
        else if (run_ev)  state_d = ST_RUN;

        div_max = (cur_state == ST_FAST) ? FAST_MAX : SLOW_MAX;
        tick    = (cur_state != ST_IDLE) && (presc_q == div_max);
        adv_now = !halt && !load && (tick || ((cur_state == ST_IDLE) && next_ev));
        sum     = {1'b0, pc_q} + {1'b0, step};

        pc_d   = pc_q;
        adv_d  = 1'b0;
        wrap_d = 1'b0;
        if (load) begin
            pc_d = load_value;
        end else if (adv_now) begin
            pc_d   = sum[WIDTH-1:0];
            adv_d  = 1'b1;
            wrap_d = sum[WIDTH];
        end

        // Re-entering the current mode is not a state change, so the count survives.
        if (load || tick || (state_d != cur_state) || (state_d == ST_IDLE))
            presc_d = '0;
        else
            presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            presc_q <= '0;
            adv_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            presc_q <= presc_d;
            adv_q   <= adv_d;
            wrap_q  <= wrap_d;
        end
    end

    assign pc    = pc_q;
    assign state = state_q;
    assign adv   = adv_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a random phase,
// all compared cycle by cycle against a countdown-based reference model.
module tb_pc_sequencer;

  localparam int W  = 8;
  localparam int SD = 4;
  localparam int FD = 2;

  // clock / reset / DUT
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         next_btn = 1'b0, run_btn = 1'b0, fast_btn = 1'b0;
  logic         halt = 1'b0, load = 1'b0;
  logic [W-1:0] load_value = '0, step = '0;
  logic [W-1:0] pc;
  logic [1:0]   state;
  logic         adv, wrap;

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(W), .SLOW_DIV(SD), .FAST_DIV(FD)) dut (
    .clk(clk), .rst(rst), .next_btn(next_btn), .run_btn(run_btn),
    .fast_btn(fast_btn), .halt(halt), .load(load), .load_value(load_value),
    .step(step), .pc(pc), .state(state), .adv(adv), .wrap(wrap)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int adv_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: counts down cycles to the next advance
  logic [W-1:0] exp_q[$];
  int           m_state = 0;
  logic [W-1:0] m_pc = '0;
  bit           m_adv = 0, m_wrap = 0;
  int           m_left = SD;
  int           m_rel = 0;
  bit   [3:0]   nh = '0, rh = '0, fh = '0;
  int           ns = 0;

  function automatic int div_of(input int s);
    return (s == 2) ? FD : SD;
  endfunction

  task automatic model_step();
    bit nev, rev, fev, due;
    int cur, nst, sum;
    if (rst) begin
      m_rel = 0; m_state = 0; m_pc = '0; m_adv = 0; m_wrap = 0;
      m_left = SD; nh = '0; rh = '0; fh = '0; ns = 0;
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      nh = {nh[2:0], next_btn};
      rh = {rh[2:0], run_btn};
      fh = {fh[2:0], fast_btn};
      if (ns < 4) ns++;
      // a press acts two samples after it is first seen, and only after a seen low
      nev = (ns >= 4) && nh[2] && !nh[3];
      rev = (ns >= 4) && rh[2] && !rh[3];
      fev = (ns >= 4) && fh[2] && !fh[3];
      cur = m_state;
      nst = halt ? 0 : fev ? 2 : rev ? 1 : cur;
      due = ((cur != 0) && (m_left == 1)) || ((cur == 0) && nev);
      m_adv = 0; m_wrap = 0;
      if (load) begin
        m_pc = load_value;
      end else if (due && !halt) begin
        sum    = int'(m_pc) + int'(step);
        m_wrap = (sum >= (1 << W));
        m_pc   = W'(sum % (1 << W));
        m_adv  = 1;
      end
      if (load || due || (nst != cur) || (nst == 0)) m_left = div_of(nst);
      else m_left--;
      m_state = nst;
    end
    exp_q.push_back(m_pc);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (adv === 1'b1) adv_seen++;
    check("pc", pc, exp_q.pop_front());
    check("state", state, m_state);
    check("adv", adv, m_adv);
    check("wrap", wrap, m_wrap);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press(input int which);
    case (which)
      0: next_btn = 1'b1;
      1: run_btn  = 1'b1;
      default: fast_btn = 1'b1;
    endcase
    cycles(4);
    next_btn = 1'b0; run_btn = 1'b0; fast_btn = 1'b0;
    cycles(4);
  endtask

  initial begin
    int waited;
    // reset
    cycles(3);
    check("rst_pc", pc, 0);
    check("rst_state", state, 0);
    rst = 1'b0;
    cycles(6);

    // single steps, step=3: action lands on the third edge after the rise
    step = 8'd3;
    adv_seen = 0;
    next_btn = 1'b1;
    cycles(2);
    check("step1_early", adv, 0);
    cycle();
    check("step1_adv", adv, 1);
    check("step1_pc", pc, 3);
    cycles(3);
    next_btn = 1'b0;
    cycles(4);
    press(0);
    check("step2_pc", pc, 6);
    check("step_adv_cnt", adv_seen, 2);

    // slow run with step=1, then halt
    step = 8'd1;
    press(1);
    check("run_state", state, 1);
    cycles(12);
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    check("halt_state", state, 0);
    cycles(8);

    // run, then fast, with a next press ignored while fast
    press(1);
    cycles(5);
    press(2);
    check("fast_state", state, 2);
    press(0);
    cycles(6);
    halt = 1'b1;
    cycle();
    halt = 1'b0;

    // carry out of 8 bits
    load = 1'b1; load_value = 8'hFE;
    cycle();
    load = 1'b0;
    step = 8'd3;
    next_btn = 1'b1;
    cycles(3);
    check("wrap_pc", pc, 8'h01);
    check("wrap_flag", wrap, 1);
    cycle();
    check("wrap_clear", wrap, 0);
    next_btn = 1'b0;
    cycles(4);

    // load lands exactly when an advance is due
    step = 8'd1;
    press(1);
    waited = 0;
    while (!(m_state == 1 && m_left == 1) && waited < 20) begin
      cycle();
      waited++;
    end
    check("load_due_reached", (waited < 20), 1);
    load = 1'b1; load_value = 8'h40;
    cycle();
    load = 1'b0;
    check("load_pc", pc, 8'h40);
    check("load_adv", adv, 0);
    cycles(3);
    check("load_no_early_adv", adv, 0);
    cycle();
    check("load_next_adv", adv, 1);
    check("load_next_pc", pc, 8'h41);

    // reset mid-run with run_btn held high
    run_btn = 1'b1;
    cycles(8);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(20);
    check("held_rst_pc", pc, 0);
    check("held_rst_state", state, 0);
    run_btn = 1'b0;
    cycles(4);
    run_btn = 1'b1;
    cycles(3);
    check("rerun_state", state, 1);
    cycles(9);
    run_btn = 1'b0;
    halt = 1'b1;
    cycle();
    halt = 1'b0;

    // random phase
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) next_btn = ~next_btn;
      if ($urandom_range(0, 7) == 0) run_btn  = ~run_btn;
      if ($urandom_range(0, 7) == 0) fast_btn = ~fast_btn;
      halt = ($urandom_range(0, 24) == 0);
      load = ($urandom_range(0, 29) == 0);
      load_value = W'($urandom);
      if ($urandom_range(0, 15) == 0) step = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0; halt = 1'b0; load = 1'b0;
    cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
